// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Decoupled instruction-fetch front end. Owns the fetch PC and the supervisor
//   bit, issues pipelined requests on a request/grant/response memory port,
//   buffers returned words in an in-order prefetch FIFO, and hands them to
//   decode over a valid/ready pair. Redirects (branch, jump, illegal-op,
//   exception) and interrupt acceptance flush the FIFO and discard in-flight
//   responses.
//
// Ports
//   clk, RESET_N        clock, asynchronous active-low reset
//   imem_req_o/addr_o   fetch request and word-aligned byte address
//   imem_gnt_i          request accepted this cycle
//   imem_rvalid_i/rdata_i  in-order response
//   inst_valid_o/data_o/pc_o, inst_ready_i   FIFO head handoff to decode
//   redir_valid_i/sel_i/target_i             redirect request
//   IRQ                 level-sensitive interrupt
//   irq_taken_o/xp_pc_o registered pulse on interrupt accept, return address
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int           W          = 32,
    parameter int           DEPTH      = 4,
    parameter int           MAX_OUT    = 2,
    parameter logic [W-1:0] RST_ADDR   = 32'h8000_0000,
    parameter logic [W-1:0] ILLOP_ADDR = 32'h8000_0004,
    parameter logic [W-1:0] X_ADDR     = 32'h8000_0008
) (
    input  logic         clk,
    input  logic         RESET_N,
    output logic         imem_req_o,
    output logic [W-1:0] imem_addr_o,
    input  logic         imem_gnt_i,
    input  logic         imem_rvalid_i,
    input  logic [W-1:0] imem_rdata_i,
    output logic         inst_valid_o,
    output logic [W-1:0] inst_data_o,
    output logic [W-1:0] inst_pc_o,
    input  logic         inst_ready_i,
    input  logic         redir_valid_i,
    input  logic [1:0]   redir_sel_i,
    input  logic [W-1:0] redir_target_i,
    input  logic         IRQ,
    output logic         irq_taken_o,
    output logic [W-1:0] xp_pc_o
);

    localparam int              AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW         = $clog2(DEPTH + 1);
    localparam logic [CW:0]     DEPTH_C    = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0]   MAX_OUT_C  = CW'(MAX_OUT);
    localparam logic [W-1:0]    ALIGN_MASK = ~W'(3);

    logic [W-1:0]  pc;           // next fetch address
    logic [W-1:0]  resp_pc;      // PC of the next response that will be kept
    logic          sup;
    logic [CW-1:0] outstanding;  // granted requests awaiting a response
    logic [CW-1:0] discard;      // stale responses still to be dropped
    logic [CW-1:0] count;        // FIFO occupancy
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [W-1:0]  data_mem [DEPTH];
    logic [W-1:0]  pc_mem   [DEPTH];

    logic          head_valid, irq_accept, flush, pop, push, grant;
    logic [CW:0]   credit;
    logic [W-1:0]  flush_target;

    assign imem_addr_o = pc;
    assign inst_data_o = data_mem[rd_ptr];
    assign inst_pc_o   = pc_mem[rd_ptr];

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        head_valid   = (count != '0);
        // Interrupts are taken only at a user-mode instruction boundary and
        // lose to an external redirect in the same cycle.
        irq_accept   = IRQ && head_valid && !inst_pc_o[W-1] && !redir_valid_i;
        flush        = redir_valid_i || irq_accept;
        inst_valid_o = head_valid && !irq_accept;
        pop          = inst_valid_o && inst_ready_i;
        // Credit counts in-flight words too, so a response always finds room.
        credit       = {1'b0, outstanding} + {1'b0, count};
        imem_req_o   = RESET_N && (credit < DEPTH_C) && (outstanding < MAX_OUT_C) && !flush;
        grant        = imem_req_o && imem_gnt_i;
        push         = imem_rvalid_i && (discard == '0) && !flush;

        flush_target = X_ADDR;
        if (redir_valid_i) begin
            case (redir_sel_i)
                2'b00:   flush_target = redir_target_i & ALIGN_MASK;
                // A jump may drop to user mode but never raise to supervisor.
                2'b01:   flush_target = {redir_target_i[W-1] & sup, redir_target_i[W-2:0]} & ALIGN_MASK;
                2'b10:   flush_target = ILLOP_ADDR;
                default: flush_target = X_ADDR;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            pc          <= RST_ADDR;
            resp_pc     <= RST_ADDR;
            sup         <= 1'b1;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            irq_taken_o <= 1'b0;
            xp_pc_o     <= '0;
        end else begin
            irq_taken_o <= irq_accept;
            if (irq_accept) xp_pc_o <= inst_pc_o + W'(4);
            if (pop)        sup     <= inst_pc_o[W-1];

            if (flush) begin
                // Grant this cycle is ignored; a response arriving now is
                // dropped, and every one still in flight will be too.
                pc          <= flush_target;
                resp_pc     <= flush_target;
                outstanding <= outstanding - CW'(imem_rvalid_i);
                discard     <= outstanding - CW'(imem_rvalid_i);
                count       <= '0;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
            end else begin
                if (grant) pc <= pc + W'(4);
                outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid_i);
                if (imem_rvalid_i && (discard != '0)) discard <= discard - CW'(1);
                if (push) begin
                    resp_pc <= resp_pc + W'(4);
                    wr_ptr  <= wr_ptr + AW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // NOTE: the FIFO storage is reset because the head word and PC are
    // visible outputs whose reset value must be zero.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (push) begin
            data_mem[wr_ptr] <= imem_rdata_i;
            pc_mem[wr_ptr]   <= resp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. A fixed-latency memory model answers every
//   granted request with ~address; a monitor records every delivered
//   instruction. Each scenario task drives its stimulus and compares DUT
//   outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        RESET_N;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_data_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;
    logic        redir_valid_i;
    logic [1:0]  redir_sel_i;
    logic [31:0] redir_target_i;
    logic        IRQ;
    logic        irq_taken_o;
    logic [31:0] xp_pc_o;

    fetch_unit dut (
        .clk            (clk),
        .RESET_N        (RESET_N),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_gnt_i     (imem_gnt_i),
        .imem_rvalid_i  (imem_rvalid_i),
        .imem_rdata_i   (imem_rdata_i),
        .inst_valid_o   (inst_valid_o),
        .inst_data_o    (inst_data_o),
        .inst_pc_o      (inst_pc_o),
        .inst_ready_i   (inst_ready_i),
        .redir_valid_i  (redir_valid_i),
        .redir_sel_i    (redir_sel_i),
        .redir_target_i (redir_target_i),
        .IRQ            (IRQ),
        .irq_taken_o    (irq_taken_o),
        .xp_pc_o        (xp_pc_o)
    );

    initial forever #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } inst_t;

    req_t  pend[$];
    inst_t got[$];
    int    cyc     = 0;
    int    mem_lat = 1;
    int    n_gnt   = 0;
    int    n_irq   = 0;
    int    n_vec   = 0;
    int    n_err   = 0;

    // Memory responder: answers in order, mem_lat cycles after the grant.
    initial begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!RESET_N) pend.delete();
            if (RESET_N && pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = ~pend[0].addr;
                void'(pend.pop_front());
            end else begin
                imem_rvalid_i = 1'b0;
                imem_rdata_i  = '0;
            end
        end
    end

    // Grant recorder and delivery monitor, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (RESET_N) begin
            if (imem_req_o && imem_gnt_i) begin
                pend.push_back('{addr: imem_addr_o, due: cyc + mem_lat});
                n_gnt++;
            end
            if (inst_valid_o && inst_ready_i) got.push_back('{pc: inst_pc_o, data: inst_data_o});
            if (irq_taken_o) n_irq++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000 ns, expected completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the caller at the start of cycle 0 (reset just released).
    task automatic reset_dut(input int lat);
        step();
        mem_lat       = lat;
        RESET_N       = 1'b0;
        redir_valid_i = 1'b0;
        redir_sel_i   = 2'b00;
        IRQ           = 1'b0;
        step();
        step();
        RESET_N = 1'b1;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; imem_gnt_i = 1'b1; inst_ready_i = 1'b1; mem_lat = 1;
        redir_valid_i = 1'b0; redir_sel_i = 2'b00; redir_target_i = '0; IRQ = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (imem_req_o !== 1'b0)   begin n_err++; $display("FAIL rst_req: got %b exp 0", imem_req_o); end
        n_vec++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b exp 0", inst_valid_o); end
        n_vec++; if (irq_taken_o !== 1'b0)  begin n_err++; $display("FAIL rst_irq: got %b exp 0", irq_taken_o); end
        n_vec++; if (xp_pc_o !== 32'h0)     begin n_err++; $display("FAIL rst_xp: got %h exp 0", xp_pc_o); end
        n_vec++; if (inst_data_o !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h exp 0", inst_data_o); end
        n_vec++; if (inst_pc_o !== 32'h0)   begin n_err++; $display("FAIL rst_pc: got %h exp 0", inst_pc_o); end
        step();
        RESET_N = 1'b1;
        repeat (3) step();
        @(negedge clk);
        n_vec++; if (inst_valid_o !== 1'b1) begin n_err++; $display("FAIL pre_rst_valid: got %b exp 1", inst_valid_o); end
        step();
        RESET_N = 1'b0;
        #1;
        n_vec++; if (inst_valid_o !== 1'b0)  begin n_err++; $display("FAIL midrst_valid: got %b exp 0", inst_valid_o); end
        n_vec++; if (imem_req_o !== 1'b0)    begin n_err++; $display("FAIL midrst_req: got %b exp 0", imem_req_o); end
        n_vec++; if (inst_pc_o !== 32'h0)    begin n_err++; $display("FAIL midrst_pc: got %h exp 0", inst_pc_o); end
    endtask

    task automatic test_stream();
        inst_ready_i = 1'b1; imem_gnt_i = 1'b1;
        reset_dut(1);
        @(negedge clk);
        n_vec++; if (imem_req_o !== 1'b1)            begin n_err++; $display("FAIL c0_req: got %b exp 1", imem_req_o); end
        n_vec++; if (imem_addr_o !== 32'h8000_0000)  begin n_err++; $display("FAIL c0_addr: got %h exp 80000000", imem_addr_o); end
        n_vec++; if (inst_valid_o !== 1'b0)          begin n_err++; $display("FAIL c0_valid: got %b exp 0", inst_valid_o); end
        step(); @(negedge clk);
        n_vec++; if (imem_addr_o !== 32'h8000_0004)  begin n_err++; $display("FAIL c1_addr: got %h exp 80000004", imem_addr_o); end
        n_vec++; if (inst_valid_o !== 1'b0)          begin n_err++; $display("FAIL c1_valid: got %b exp 0", inst_valid_o); end
        step(); @(negedge clk);
        n_vec++; if (inst_valid_o !== 1'b1)          begin n_err++; $display("FAIL c2_valid: got %b exp 1", inst_valid_o); end
        n_vec++; if (inst_pc_o !== 32'h8000_0000)    begin n_err++; $display("FAIL c2_pc: got %h exp 80000000", inst_pc_o); end
        n_vec++; if (inst_data_o !== 32'h7fff_ffff)  begin n_err++; $display("FAIL c2_data: got %h exp 7fffffff", inst_data_o); end
        for (int i = 1; i < 5; i++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'h8000_0000 + 32'(4 * i);
            step(); @(negedge clk);
            n_vec++; if (inst_valid_o !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %b exp 1", i, inst_valid_o); end
            n_vec++; if (inst_pc_o !== exp_pc)  begin n_err++; $display("FAIL stream_pc[%0d]: got %h exp %h", i, inst_pc_o, exp_pc); end
        end
    endtask

    task automatic test_backpressure();
        int nb, gb;
        inst_ready_i = 1'b0; imem_gnt_i = 1'b1;
        reset_dut(1);
        nb = n_gnt; gb = got.size();
        repeat (8) step();
        @(negedge clk);
        n_vec++; if (imem_req_o !== 1'b0)           begin n_err++; $display("FAIL bp_req: got %b exp 0", imem_req_o); end
        n_vec++; if (inst_valid_o !== 1'b1)         begin n_err++; $display("FAIL bp_valid: got %b exp 1", inst_valid_o); end
        n_vec++; if (inst_pc_o !== 32'h8000_0000)   begin n_err++; $display("FAIL bp_head: got %h exp 80000000", inst_pc_o); end
        step();
        n_vec++; if (n_gnt - nb !== 4)              begin n_err++; $display("FAIL bp_grants: got %0d exp 4", n_gnt - nb); end
        inst_ready_i = 1'b1;
        repeat (10) step();
        n_vec++; if (got.size() - gb < 8)           begin n_err++; $display("FAIL bp_count: got %0d exp >=8", got.size() - gb); end
        for (int i = 0; i < 8 && gb + i < got.size(); i++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'h8000_0000 + 32'(4 * i);
            n_vec++; if (got[gb+i].pc !== exp_pc)   begin n_err++; $display("FAIL bp_pc[%0d]: got %h exp %h", i, got[gb+i].pc, exp_pc); end
            n_vec++; if (got[gb+i].data !== ~exp_pc) begin n_err++; $display("FAIL bp_data[%0d]: got %h exp %h", i, got[gb+i].data, ~exp_pc); end
        end
    endtask

    task automatic test_redirect();
        int gb;
        inst_ready_i = 1'b1; imem_gnt_i = 1'b1;
        reset_dut(3);
        gb = got.size();
        step(); step(); @(negedge clk);
        n_vec++; if (imem_req_o !== 1'b0)          begin n_err++; $display("FAIL maxout_req: got %b exp 0", imem_req_o); end
        step();
        redir_valid_i = 1'b1; redir_sel_i = 2'b00; redir_target_i = 32'h0000_0103;
        @(negedge clk);
        n_vec++; if (imem_req_o !== 1'b0)          begin n_err++; $display("FAIL redir_req: got %b exp 0", imem_req_o); end
        step();
        redir_valid_i = 1'b0;
        @(negedge clk);
        n_vec++; if (imem_req_o !== 1'b1)          begin n_err++; $display("FAIL post_redir_req: got %b exp 1", imem_req_o); end
        n_vec++; if (imem_addr_o !== 32'h0000_0100) begin n_err++; $display("FAIL post_redir_addr: got %h exp 00000100", imem_addr_o); end
        repeat (6) step();
        n_vec++; if (got.size() - gb < 2)          begin n_err++; $display("FAIL redir_count: got %0d exp >=2", got.size() - gb); end
        if (got.size() - gb >= 2) begin
            n_vec++; if (got[gb].pc !== 32'h0000_0100)     begin n_err++; $display("FAIL redir_first_pc: got %h exp 00000100", got[gb].pc); end
            n_vec++; if (got[gb].data !== 32'hffff_feff)   begin n_err++; $display("FAIL redir_first_data: got %h exp fffffeff", got[gb].data); end
            n_vec++; if (got[gb+1].pc !== 32'h0000_0104)   begin n_err++; $display("FAIL redir_second_pc: got %h exp 00000104", got[gb+1].pc); end
        end
    endtask

    task automatic test_jump();
        inst_ready_i = 1'b1; imem_gnt_i = 1'b1;
        reset_dut(1);
        redir_valid_i = 1'b1; redir_sel_i = 2'b00; redir_target_i = 32'h0000_0200;
        @(negedge clk);
        n_vec++; if (imem_req_o !== 1'b0)            begin n_err++; $display("FAIL br_req: got %b exp 0", imem_req_o); end
        step();
        redir_valid_i = 1'b0;
        @(negedge clk);
        n_vec++; if (imem_addr_o !== 32'h0000_0200)  begin n_err++; $display("FAIL br_addr: got %h exp 00000200", imem_addr_o); end
        repeat (4) step();
        redir_valid_i = 1'b1; redir_sel_i = 2'b01; redir_target_i = 32'h8000_0040;
        step();
        redir_valid_i = 1'b0;
        @(negedge clk);
        n_vec++; if (imem_req_o !== 1'b1)            begin n_err++; $display("FAIL jmp_user_req: got %b exp 1", imem_req_o); end
        n_vec++; if (imem_addr_o !== 32'h0000_0040)  begin n_err++; $display("FAIL jmp_user_addr: got %h exp 00000040", imem_addr_o); end
        reset_dut(1);
        redir_valid_i = 1'b1; redir_sel_i = 2'b01; redir_target_i = 32'h8000_0040;
        step();
        redir_valid_i = 1'b0;
        @(negedge clk);
        n_vec++; if (imem_addr_o !== 32'h8000_0040)  begin n_err++; $display("FAIL jmp_sup_addr: got %h exp 80000040", imem_addr_o); end
        redir_valid_i = 1'b0;
    endtask

    task automatic test_irq();
        int gb, ib;
        inst_ready_i = 1'b0; imem_gnt_i = 1'b1;
        reset_dut(1);
        redir_valid_i = 1'b1; redir_sel_i = 2'b00; redir_target_i = 32'h0000_0010;
        step(); redir_valid_i = 1'b0;
        step(); step();
        IRQ = 1'b1;
        @(negedge clk);
        n_vec++; if (inst_valid_o !== 1'b0)          begin n_err++; $display("FAIL irq_valid_forced: got %b exp 0", inst_valid_o); end
        step();
        IRQ = 1'b0;
        @(negedge clk);
        n_vec++; if (irq_taken_o !== 1'b1)           begin n_err++; $display("FAIL irq_taken: got %b exp 1", irq_taken_o); end
        n_vec++; if (xp_pc_o !== 32'h0000_0014)      begin n_err++; $display("FAIL irq_xp: got %h exp 00000014", xp_pc_o); end
        n_vec++; if (imem_addr_o !== 32'h8000_0008)  begin n_err++; $display("FAIL irq_vec_addr: got %h exp 80000008", imem_addr_o); end
        step(); @(negedge clk);
        n_vec++; if (irq_taken_o !== 1'b0)           begin n_err++; $display("FAIL irq_pulse: got %b exp 0", irq_taken_o); end
        step();
        gb = got.size();
        inst_ready_i = 1'b1;
        repeat (4) step();
        n_vec++; if (got.size() <= gb)               begin n_err++; $display("FAIL irq_deliver: got %0d entries exp >=1", got.size() - gb); end
        if (got.size() > gb) begin
            n_vec++; if (got[gb].pc !== 32'h8000_0008)   begin n_err++; $display("FAIL irq_next_pc: got %h exp 80000008", got[gb].pc); end
            n_vec++; if (got[gb].data !== 32'h7fff_fff7) begin n_err++; $display("FAIL irq_next_data: got %h exp 7ffffff7", got[gb].data); end
        end
        // Supervisor-mode head: interrupt must be ignored.
        inst_ready_i = 1'b0;
        reset_dut(1);
        ib = n_irq;
        redir_valid_i = 1'b1; redir_sel_i = 2'b00; redir_target_i = 32'h8000_0010;
        step(); redir_valid_i = 1'b0;
        step(); step();
        IRQ = 1'b1;
        @(negedge clk);
        n_vec++; if (inst_valid_o !== 1'b1)          begin n_err++; $display("FAIL sup_valid: got %b exp 1", inst_valid_o); end
        n_vec++; if (inst_pc_o !== 32'h8000_0010)    begin n_err++; $display("FAIL sup_head: got %h exp 80000010", inst_pc_o); end
        repeat (3) step();
        IRQ = 1'b0;
        n_vec++; if (n_irq - ib !== 0)               begin n_err++; $display("FAIL sup_irq: got %0d pulses exp 0", n_irq - ib); end
    endtask

    task automatic test_irq_vs_redir();
        int  gb, ib, hits;
        bit  seen;
        inst_ready_i = 1'b0; imem_gnt_i = 1'b1;
        reset_dut(1);
        redir_valid_i = 1'b1; redir_sel_i = 2'b00; redir_target_i = 32'h0000_0010;
        step(); redir_valid_i = 1'b0;
        step(); step();
        ib = n_irq;
        IRQ = 1'b1; redir_valid_i = 1'b1; redir_sel_i = 2'b10;
        step();
        redir_valid_i = 1'b0; inst_ready_i = 1'b1;
        gb = got.size();
        @(negedge clk);
        n_vec++; if (irq_taken_o !== 1'b0)           begin n_err++; $display("FAIL both_irq: got %b exp 0", irq_taken_o); end
        n_vec++; if (imem_addr_o !== 32'h8000_0004)  begin n_err++; $display("FAIL both_addr: got %h exp 80000004", imem_addr_o); end
        repeat (5) step();
        n_vec++; if (n_irq - ib !== 0)               begin n_err++; $display("FAIL both_sup_irq: got %0d pulses exp 0", n_irq - ib); end
        n_vec++; if (got.size() - gb < 2)            begin n_err++; $display("FAIL both_count: got %0d exp >=2", got.size() - gb); end
        if (got.size() - gb >= 2) begin
            n_vec++; if (got[gb].pc !== 32'h8000_0004)   begin n_err++; $display("FAIL both_pc0: got %h exp 80000004", got[gb].pc); end
            n_vec++; if (got[gb+1].pc !== 32'h8000_0008) begin n_err++; $display("FAIL both_pc1: got %h exp 80000008", got[gb+1].pc); end
        end
        // Move to a user-mode stream with IRQ still asserted.
        redir_valid_i = 1'b1; redir_sel_i = 2'b00; redir_target_i = 32'h0000_0020;
        step();
        redir_valid_i = 1'b0;
        gb = got.size();
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (irq_taken_o) seen = 1'b1;
            else step();
        end
        n_vec++; if (seen !== 1'b1)                  begin n_err++; $display("FAIL user_irq_timeout: got no pulse in 12 cycles exp pulse"); end
        n_vec++; if (xp_pc_o !== 32'h0000_0024)      begin n_err++; $display("FAIL user_irq_xp: got %h exp 00000024", xp_pc_o); end
        IRQ = 1'b0;
        step();
        hits = 0;
        for (int i = gb; i < got.size(); i++) if (got[i].pc == 32'h0000_0020) hits++;
        n_vec++; if (hits !== 0)                     begin n_err++; $display("FAIL user_irq_head: got %0d deliveries of 00000020 exp 0", hits); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_jump();
        test_irq();
        test_irq_vs_redir();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Decoupled, parametrised instruction-fetch front end for the next-generation processor. Replaces the single-cycle PC plus combinational instruction read with a pipelined request/grant/response memory port, an in-order prefetch FIFO, and a valid/ready handoff to decode.
- Owns the PC, the supervisor bit (PC MSB), the reset, exception and illegal-op vectors, and interrupt acceptance at instruction boundaries.

Parameters:
- W, 32: address and instruction width.
- DEPTH, 4: prefetch FIFO entries; power of 2, at least 2.
- MAX_OUT, 2: maximum outstanding memory requests; must be at most DEPTH.
- RST_ADDR, 32'h80000000: PC after reset.
- ILLOP_ADDR, 32'h80000004: illegal-opcode vector.
- X_ADDR, 32'h80000008: interrupt/exception vector.

Ports:
- clk  in  1  clock.
- RESET_N  in  1  asynchronous active-low reset.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  W  fetch byte address; bits [1:0] are always 0.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response valid; responses return in request order, at least 1 cycle after grant.
- imem_rdata_i  in  W  instruction word.
- inst_valid_o  out  1  FIFO head valid to decode.
- inst_data_o  out  W  head instruction.
- inst_pc_o  out  W  head PC.
- inst_ready_i  in  1  decode consumes head.
- redir_valid_i  in  1  redirect request.
- redir_sel_i  in  2  00 branch, 01 jump, 10 illegal-op, 11 exception.
- redir_target_i  in  W  target for 00 and 01.
- IRQ  in  1  level-sensitive interrupt.
- irq_taken_o  out  1  one-cycle pulse when the interrupt is accepted.
- xp_pc_o  out  W  return address for XP; valid while irq_taken_o is high.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low on RESET_N.
- Reset values:
  - fetch PC = RST_ADDR; supervisor bit sup = 1.
  - FIFO empty; outstanding count = 0; discard count = 0.
  - imem_req_o = 0, inst_valid_o = 0, irq_taken_o = 0.
  - xp_pc_o, inst_data_o, inst_pc_o = 0.
- Issue:
  - imem_req_o = 1 when outstanding + FIFO occupancy < DEPTH, outstanding < MAX_OUT, and redir_valid_i = 0.
  - Hold imem_addr_o stable until granted. On grant: PC <= PC+4 (wraps modulo 2^W); outstanding++.
- Response: each imem_rvalid_i decrements outstanding.
  - If discard > 0: drop the word and decrement discard.
  - Otherwise push {data, pc} into the FIFO, where pc is tracked by a parallel in-order PC queue.
  - The FIFO never overflows, because of the issue credit rule.
- Delivery: the head is presented while the FIFO is non-empty. It pops on inst_valid_o & inst_ready_i; sup <= inst_pc_o[W-1] on pop.
- Throughput and latency: with 1-cycle memory latency and continuous ready, one instruction per cycle after the first. First inst_valid_o comes 2 cycles after reset release (grant at cycle 0, response at cycle 1, valid at cycle 2).
- A push and a pop in the same cycle are both honoured; occupancy is unchanged.
- Redirect (redir_valid_i = 1), in one cycle:
  - Flush the FIFO.
  - discard <= outstanding, including any response arriving this same cycle.
  - Set PC from redir_sel_i:
    - 00: PC <= redir_target_i & ~3.
    - 01: PC <= {redir_target_i[W-1] & sup, redir_target_i[W-2:2], 2'b00}. A jump may clear supervisor mode but never set it.
    - 10: PC <= ILLOP_ADDR.
    - 11: PC <= X_ADDR.
  - A grant arriving in the same cycle is ignored; the request is not issued.
  - The next request goes out on the following cycle.
- Interrupt:
  - Accepted in a cycle where all of these hold: IRQ = 1, inst_valid_o = 1, inst_pc_o[W-1] = 0, redir_valid_i = 0.
  - In that cycle inst_valid_o is forced to 0, so the head is not delivered.
  - Then: irq_taken_o = 1; xp_pc_o = inst_pc_o + 4; internal redirect to X_ADDR with the same flush/discard rules.
  - Never accepted in supervisor mode (head PC MSB = 1).
  - An external redirect in the same cycle wins; IRQ is re-evaluated on the new stream.
- Reset mid-operation: all state returns to reset values immediately. Responses still in flight from before reset must not arrive after reset release (system requirement on the memory).

Test Plan:
- Reset release, 1-cycle memory, ready = 1 → addresses 80000000, 80000004, 80000008…; inst_valid_o first high on cycle 2; one instruction per cycle thereafter.
- Hold inst_ready_i = 0 with DEPTH = 4 → exactly 4 words buffered, imem_req_o drops; on release, words are delivered in order with no loss or duplication.
- MAX_OUT = 2, 3-cycle memory latency, redir_sel_i = 00 with target 00000103 while 2 requests are outstanding → both stale responses dropped; next fetch address 00000100; first delivered PC 00000100.
- Jump from user mode (sup = 0) with target 80000040 → PC becomes 00000040. Same jump with sup = 1 → 80000040.
- IRQ = 1 with head PC 00000010 → irq_taken_o pulses; xp_pc_o = 00000014; next delivered PC 80000008. IRQ with head PC 80000010 → ignored.
- IRQ and redir (sel 10) in the same cycle → no irq_taken_o; fetch from 80000004, then the interrupt is accepted only once a user-mode head appears.
